// File: rtl/char_pkg.sv
// char_pkg: shared state type and default sizing for the
// ring-oscillator measurement sequencer.
package char_pkg;

   localparam int DEF_NUM_OSC = 8;
   localparam int DEF_CNT_W   = 16;
   localparam int DEF_WIN_W   = 16;
   localparam int DEF_WARMUP  = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_MEASURE,
      ST_FINISH
   } char_state_t;

endpackage

// File: rtl/char_edge_sync.sv
// char_edge_sync: 2-flop synchronizer plus registered rising-edge
// detect for one asynchronous oscillator line.
// Ports: clk, rst_n (async low), i_d (async in), o_rise (1-clk pulse).
module char_edge_sync
   import char_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_prev;
   logic r_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_s1   <= i_d;
         r_s2   <= r_s1;
         r_prev <= r_s2;
         r_rise <= r_s2 & ~r_prev;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/char_meas_sequencer.sv
// char_meas_sequencer: enables one ring oscillator, waits WARMUP
// clocks, counts its synchronized rising edges over a window.
// Ports: clk, rst_n, ena, start, osc_sel, window, osc_in in;
//        osc_en, busy, done, result, overflow, sel_err out.
module char_meas_sequencer
   import char_pkg::*;
#(
   parameter int NUM_OSC = DEF_NUM_OSC,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int WIN_W   = DEF_WIN_W,
   parameter int WARMUP  = DEF_WARMUP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               start,
   input  logic [2:0]         osc_sel,
   input  logic [WIN_W-1:0]   window,
   input  logic [NUM_OSC-1:0] osc_in,
   output logic [NUM_OSC-1:0] osc_en,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   result,
   output logic               overflow,
   output logic               sel_err
);

   localparam int WU_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;
   localparam int WU_W =
      (WU_LAST > 0) ? $clog2(WU_LAST + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   char_state_t        r_state;
   logic [2:0]         r_sel;
   logic [WIN_W-1:0]   r_win;
   logic [WU_W-1:0]    r_wcnt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic               r_err;
   logic [NUM_OSC-1:0] r_osc_en;
   logic               r_busy;
   logic               r_done;
   logic [CNT_W-1:0]   r_result;
   logic               r_overflow;
   logic               r_sel_err;

   logic [NUM_OSC-1:0] w_rise;
   logic [NUM_OSC-1:0] w_sel_mask;
   logic [NUM_OSC-1:0] w_start_mask;
   logic               w_sel_bad;
   logic               w_hit;

   for (genvar g = 0; g < NUM_OSC; g++) begin : g_sync
      char_edge_sync u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_d    (osc_in[g]),
         .o_rise (w_rise[g])
      );
   end

   assign w_sel_bad    = ({29'd0, osc_sel} >= 32'(NUM_OSC));
   assign w_start_mask = NUM_OSC'(1) << osc_sel;
   // Edge mux steered by the select latched at start.
   assign w_sel_mask   = NUM_OSC'(1) << r_sel;
   assign w_hit        = |(w_rise & w_sel_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_win      <= '0;
         r_wcnt     <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_err      <= 1'b0;
         r_osc_en   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_sel_err  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (!ena) begin
            // Abort: published results stay untouched.
            r_state  <= ST_IDLE;
            r_osc_en <= '0;
            r_busy   <= 1'b0;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_sel  <= osc_sel;
                     r_win  <= window;
                     r_wcnt <= '0;
                     r_cnt  <= '0;
                     r_ovf  <= 1'b0;
                     if (w_sel_bad) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                     end else begin
                        r_err    <= 1'b0;
                        r_osc_en <= w_start_mask;
                        r_busy   <= 1'b1;
                        r_state  <= ST_WARMUP;
                     end
                  end
               end
               ST_WARMUP: begin
                  if (r_wcnt == WU_W'(WU_LAST)) begin
                     if (r_win == '0) begin
                        r_osc_en <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_FINISH;
                     end else begin
                        r_state <= ST_MEASURE;
                     end
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
               ST_MEASURE: begin
                  if (w_hit) begin
                     if (r_cnt != CNT_MAX)
                        r_cnt <= r_cnt + 1'b1;
                     // Flag as soon as the count pins at all-ones.
                     if (r_cnt >= CNT_MAX - 1'b1)
                        r_ovf <= 1'b1;
                  end
                  if (r_win == WIN_W'(1)) begin
                     r_osc_en <= '0;
                     r_busy   <= 1'b0;
                     r_state  <= ST_FINISH;
                  end else begin
                     r_win <= r_win - 1'b1;
                  end
               end
               ST_FINISH: begin
                  r_result   <= r_cnt;
                  r_overflow <= r_ovf;
                  r_sel_err  <= r_err;
                  r_done     <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign osc_en   = r_osc_en;
   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_result;
   assign overflow = r_overflow;
   assign sel_err  = r_sel_err;

endmodule
